// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM encoding, screen/paddle/ball geometry defaults,
// the serve centre point and the ball state record.
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_MOVE  = 3'd2,
    S_CHECK = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BALL_SIZE   = 10;
  localparam int DEF_PADDLE_W    = 10;
  localparam int DEF_PADDLE_H    = 50;
  localparam int DEF_P1_X        = 20;
  localparam int DEF_P2_X        = 620;
  localparam int DEF_SPEED       = 2;
  localparam int DEF_WIN_SCORE   = 9;
  localparam int DEF_SERVE_DELAY = 60;

  localparam int CENTRE_X = 315;
  localparam int CENTRE_Y = 235;

  // All geometry compares run at this width so sums never wrap.
  typedef logic [11:0] coord_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        dir_r;
    logic        dir_d;
  } ball_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game-controller bus: tick/start/paddle inputs and ball/score/status outputs.
interface pong_game_ctrl_if;
  logic        tick;
  logic        start;
  logic [9:0]  p1_pos;
  logic [9:0]  p2_pos;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic        point;
  logic        game_over;
  logic [2:0]  state_o;

  modport master (
    output tick, start, p1_pos, p2_pos,
    input  ball_x, ball_y, score1, score2, point, game_over, state_o
  );

  modport slave (
    input  tick, start, p1_pos, p2_pos,
    output ball_x, ball_y, score1, score2, point, game_over, state_o
  );
endinterface

// File: rtl/pong_collide.sv
// Combinational ball-vs-paddle overlap test; LEFT selects which X edge is inclusive.
module pong_collide
  import pong_pkg::*;
#(
  parameter int PX   = DEF_P1_X,
  parameter int PW   = DEF_PADDLE_W,
  parameter int PH   = DEF_PADDLE_H,
  parameter int BS   = DEF_BALL_SIZE,
  parameter bit LEFT = 1'b1
) (
  input  coord_t bx,
  input  coord_t by,
  input  coord_t pos,
  output logic   hit
);
  logic x_ov, y_ov;

  assign y_ov = (by + coord_t'(BS) > pos) && (by < pos + coord_t'(PH));

  generate
    if (LEFT) begin : g_left
      assign x_ov = (bx <= coord_t'(PX + PW)) && (bx + coord_t'(BS) > coord_t'(PX));
    end else begin : g_right
      assign x_ov = (bx + coord_t'(BS) >= coord_t'(PX)) && (bx < coord_t'(PX + PW));
    end
  endgenerate

  assign hit = x_ov && y_ov;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve countdown, per-tick ball motion, paddle/miss
// checking and score keeping.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int PADDLE_W    = DEF_PADDLE_W,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int P1_X        = DEF_P1_X,
  parameter int P2_X        = DEF_P2_X,
  parameter int SPEED       = DEF_SPEED,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_DELAY = DEF_SERVE_DELAY
) (
  input  logic              clk,
  input  logic              reset,
  pong_game_ctrl_if.slave   bus
);
  localparam coord_t      MAX_X    = coord_t'(SCREEN_W - BALL_SIZE);
  localparam coord_t      MAX_Y    = coord_t'(SCREEN_H - BALL_SIZE);
  localparam coord_t      SPD      = coord_t'(SPEED);
  localparam coord_t      HIT1_X   = coord_t'(P1_X + PADDLE_W);
  localparam coord_t      HIT2_X   = coord_t'(P2_X - BALL_SIZE);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_LD = 16'(SERVE_DELAY);
  localparam ball_t       BALL_RST = '{x: 11'(CENTRE_X), y: 10'(CENTRE_Y),
                                       dir_r: 1'b1, dir_d: 1'b1};

  state_t      state, state_nx;
  ball_t       ball, ball_nx;
  logic [3:0]  score1, score2, score1_nx, score2_nx, inc_score;
  logic [15:0] serve_cnt, serve_nx;
  logic        left_scores, left_scores_nx;
  logic        hit1, hit2;
  coord_t      bx, by;

  assign bx = coord_t'(ball.x);
  assign by = coord_t'(ball.y);

  pong_collide #(.PX(P1_X), .PW(PADDLE_W), .PH(PADDLE_H), .BS(BALL_SIZE), .LEFT(1'b1))
    u_col_p1 (.bx(bx), .by(by), .pos(coord_t'(bus.p1_pos)), .hit(hit1));

  pong_collide #(.PX(P2_X), .PW(PADDLE_W), .PH(PADDLE_H), .BS(BALL_SIZE), .LEFT(1'b0))
    u_col_p2 (.bx(bx), .by(by), .pos(coord_t'(bus.p2_pos)), .hit(hit2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ball        <= BALL_RST;
      score1      <= '0;
      score2      <= '0;
      serve_cnt   <= '0;
      left_scores <= 1'b0;
    end else begin
      state       <= state_nx;
      ball        <= ball_nx;
      score1      <= score1_nx;
      score2      <= score2_nx;
      serve_cnt   <= serve_nx;
      left_scores <= left_scores_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    ball_nx        = ball;
    score1_nx      = score1;
    score2_nx      = score2;
    serve_nx       = serve_cnt;
    left_scores_nx = left_scores;
    inc_score      = '0;
    case (state)
      S_IDLE: begin
        ball_nx.x = BALL_RST.x;
        ball_nx.y = BALL_RST.y;
        if (bus.start) begin
          serve_nx = SERVE_LD;
          state_nx = S_SERVE;
        end
      end
      S_SERVE: begin
        if (bus.tick) begin
          if (serve_cnt == '0) state_nx = S_MOVE;
          else                 serve_nx = serve_cnt - 16'd1;
        end
      end
      S_MOVE: begin
        if (bus.tick) begin
          if (ball.dir_d) begin
            if (by + SPD >= MAX_Y) begin
              ball_nx.y     = 10'(MAX_Y);
              ball_nx.dir_d = 1'b0;
            end else begin
              ball_nx.y = 10'(by + SPD);
            end
          end else if (by < SPD) begin
            ball_nx.y     = 10'd0;
            ball_nx.dir_d = 1'b1;
          end else begin
            ball_nx.y = 10'(by - SPD);
          end
          if (ball.dir_r) ball_nx.x = (bx + SPD > MAX_X) ? 11'(MAX_X) : 11'(bx + SPD);
          else            ball_nx.x = (bx < SPD) ? 11'd0 : 11'(bx - SPD);
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        // Paddle hits are tested before misses so a late save still counts.
        state_nx = S_MOVE;
        if (!ball.dir_r && hit1) begin
          ball_nx.x     = 11'(HIT1_X);
          ball_nx.dir_r = 1'b1;
        end else if (ball.dir_r && hit2) begin
          ball_nx.x     = 11'(HIT2_X);
          ball_nx.dir_r = 1'b0;
        end else if (!ball.dir_r && bx <= SPD) begin
          left_scores_nx = 1'b0;
          state_nx       = S_POINT;
        end else if (ball.dir_r && bx >= MAX_X - SPD) begin
          left_scores_nx = 1'b1;
          state_nx       = S_POINT;
        end
      end
      S_POINT: begin
        inc_score = sat_inc(left_scores ? score1 : score2, WIN);
        if (left_scores) score1_nx = inc_score;
        else             score2_nx = inc_score;
        ball_nx.x     = BALL_RST.x;
        ball_nx.y     = BALL_RST.y;
        // Serve heads toward whoever conceded.
        ball_nx.dir_r = left_scores;
        if (inc_score == WIN) begin
          state_nx = S_OVER;
        end else begin
          serve_nx = SERVE_LD;
          state_nx = S_SERVE;
        end
      end
      S_OVER: begin
        ball_nx.x = BALL_RST.x;
        ball_nx.y = BALL_RST.y;
        if (bus.start) begin
          score1_nx = '0;
          score2_nx = '0;
          serve_nx  = SERVE_LD;
          state_nx  = S_SERVE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.ball_x    = ball.x;
  assign bus.ball_y    = ball.y;
  assign bus.score1    = score1;
  assign bus.score2    = score2;
  assign bus.point     = (state == S_POINT);
  assign bus.game_over = (state == S_OVER);
  assign bus.state_o   = state;
endmodule
